alu_op_sequencer: RTL

- Controller that sequences the register-file / ALU / flags datapath.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them into the datapath control set: opCode, a_select, b_select, use_imm, immediate and regEnable.
- Runs one instruction at a time through IDLE -> DECODE -> EXEC.
- Reports completion, illegal encodings, flag-write qualification and a retired-instruction count.

---
 rtl/alu_op_sequencer_pkg.sv | 61 ++++++
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_op_sequencer_decoder.sv | 48 ++++
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: instruction fields, op codes,
// FSM encoding and the decoded control bundle.
package alu_op_sequencer_pkg;

   localparam int unsigned INSTR_W  = 16;
   localparam int unsigned OPC_W    = 8;
   localparam int unsigned SEL_W    = 4;
   localparam int unsigned NREG     = 16;
   localparam int unsigned FIELD_W  = 4;
   localparam int unsigned IMM8_W   = 8;

   localparam int unsigned OP_LSB    = 12;
   localparam int unsigned RDEST_LSB = 8;
   localparam int unsigned OPEXT_LSB = 4;
   localparam int unsigned RSRC_LSB  = 0;
   localparam int unsigned IMM8_LSB  = 0;

   localparam logic [FIELD_W-1:0] OP_NOP  = 4'b0000;
   localparam logic [FIELD_W-1:0] OP_AND  = 4'b0001;
   localparam logic [FIELD_W-1:0] OP_OR   = 4'b0010;
   localparam logic [FIELD_W-1:0] OP_XOR  = 4'b0011;
   localparam logic [FIELD_W-1:0] OP_ADD  = 4'b0101;
   localparam logic [FIELD_W-1:0] OP_ADDU = 4'b0110;
   localparam logic [FIELD_W-1:0] OP_ADDC = 4'b0111;
   localparam logic [FIELD_W-1:0] OP_SUB  = 4'b1001;
   localparam logic [FIELD_W-1:0] OP_SUBC = 4'b1010;
   localparam logic [FIELD_W-1:0] OP_CMP  = 4'b1011;
   localparam logic [FIELD_W-1:0] OP_MOV  = 4'b1101;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2
   } state_e;

   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [SEL_W-1:0]   a_sel;
      logic [SEL_W-1:0]   b_sel;
      logic               use_imm;
      logic [INSTR_W-1:0] imm;
   } ctrl_t;

   // NOP is only reachable through the register form; op=0000 never reaches here as an immediate op
   function automatic logic is_legal_code(input logic [FIELD_W-1:0] code);
      case (code)
         OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_ADDC,
         OP_SUB, OP_SUBC, OP_CMP, OP_MOV: is_legal_code = 1'b1;
         default:                         is_legal_code = 1'b0;
      endcase
   endfunction

   // Logical ops and MOVI take an unsigned immediate
   function automatic logic is_zext_code(input logic [FIELD_W-1:0] code);
      case (code)
         OP_AND, OP_OR, OP_XOR, OP_MOV: is_zext_code = 1'b1;
         default:                       is_zext_code = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Instruction handshake plus datapath control/status bundle of the sequencer.
interface alu_op_sequencer_if
   import alu_op_sequencer_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic [OPC_W-1:0]   opCode;
   logic [SEL_W-1:0]   a_select;
   logic [SEL_W-1:0]   b_select;
   logic               use_imm;
   logic [INSTR_W-1:0] immediate;
   logic [NREG-1:0]    regEnable;
   logic               flag_we;
   logic               done;
   logic               illegal;
   logic [CNT_W-1:0]   retired;

   modport master (
      output instr, instr_valid,
      input  instr_ready, opCode, a_select, b_select, use_imm, immediate,
             regEnable, flag_we, done, illegal, retired
   );

   modport slave (
      input  instr, instr_valid,
      output instr_ready, opCode, a_select, b_select, use_imm, immediate,
             regEnable, flag_we, done, illegal, retired
   );
endinterface

// File: rtl/alu_op_sequencer_decoder.sv
// Combinational decode of a held instruction word into datapath controls,
// writeback/flag qualifiers and an illegal-encoding flag.
module alu_op_decoder
   import alu_op_sequencer_pkg::*;
(
   input  logic [INSTR_W-1:0] instr_i,
   output ctrl_t              ctrl_c_o,
   output logic               wb_en_c_o,
   output logic               flag_en_c_o,
   output logic               illegal_c_o
);

   logic [FIELD_W-1:0] op;
   logic [FIELD_W-1:0] rdest;
   logic [FIELD_W-1:0] op_ext;
   logic [FIELD_W-1:0] rsrc;
   logic [IMM8_W-1:0]  imm8;
   logic               reg_form;
   logic [FIELD_W-1:0] code;
   logic               legal;

   assign op       = instr_i[OP_LSB    +: FIELD_W];
   assign rdest    = instr_i[RDEST_LSB +: FIELD_W];
   assign op_ext   = instr_i[OPEXT_LSB +: FIELD_W];
   assign rsrc     = instr_i[RSRC_LSB  +: FIELD_W];
   assign imm8     = instr_i[IMM8_LSB  +: IMM8_W];
   assign reg_form = (op == OP_NOP);
   assign code     = reg_form ? op_ext : op;
   assign legal    = is_legal_code(code);

   always_comb begin
      ctrl_c_o         = '0;
      ctrl_c_o.a_sel   = rdest;
      ctrl_c_o.use_imm = !reg_form;
      if (reg_form) begin
         ctrl_c_o.opcode = {4'b0000, op_ext};
         ctrl_c_o.b_sel  = rsrc;
      end else begin
         ctrl_c_o.opcode = {op, 4'b0000};
         ctrl_c_o.imm    = is_zext_code(code) ? {8'h00, imm8} : {{8{imm8[IMM8_W-1]}}, imm8};
      end
   end

   assign wb_en_c_o   = legal && (code != OP_NOP) && (code != OP_CMP);
   assign flag_en_c_o = legal && (code != OP_NOP) && (code != OP_MOV);
   assign illegal_c_o = !legal;

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-issue IDLE -> DECODE -> EXEC controller for the regfile/ALU/flags
// datapath, with a retired-instruction counter.
module alu_op_sequencer
   import alu_op_sequencer_pkg::*;
#(
   parameter logic [OPC_W-1:0] NOP_OPCODE = 8'h00,
   parameter int unsigned      CNT_W      = 16
)(
   input  logic               clk,
   input  logic               reset,
   alu_op_sequencer_if.slave  bus
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   retired_q, retired_d;

   ctrl_t              dec_ctrl;
   logic               dec_wb_en;
   logic               dec_flag_en;
   logic               dec_illegal;

   logic               ctrl_en;
   logic               ready_c;
   logic [OPC_W-1:0]   opcode_c;
   logic [SEL_W-1:0]   a_sel_c;
   logic [SEL_W-1:0]   b_sel_c;
   logic               use_imm_c;
   logic [INSTR_W-1:0] imm_c;
   logic [NREG-1:0]    reg_en_c;
   logic               flag_we_c;
   logic               done_c;
   logic               illegal_c;

   alu_op_decoder u_decoder (
      .instr_i     (instr_q),
      .ctrl_c_o    (dec_ctrl),
      .wb_en_c_o   (dec_wb_en),
      .flag_en_c_o (dec_flag_en),
      .illegal_c_o (dec_illegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         instr_q   <= '0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   // Outputs decode from state so a reset forces IDLE values without waiting for a clock
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      ctrl_en   = 1'b0;
      ready_c   = 1'b0;
      opcode_c  = NOP_OPCODE;
      a_sel_c   = '0;
      b_sel_c   = '0;
      use_imm_c = 1'b0;
      imm_c     = '0;
      reg_en_c  = '0;
      flag_we_c = 1'b0;
      done_c    = 1'b0;
      illegal_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ready_c = 1'b1;
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ctrl_en = 1'b1;
            if (dec_illegal) begin
               illegal_c = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            ctrl_en   = 1'b1;
            reg_en_c  = dec_wb_en ? (NREG'(1) << dec_ctrl.a_sel) : '0;
            flag_we_c = dec_flag_en;
            done_c    = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (ctrl_en) begin
         opcode_c  = dec_ctrl.opcode;
         a_sel_c   = dec_ctrl.a_sel;
         b_sel_c   = dec_ctrl.b_sel;
         use_imm_c = dec_ctrl.use_imm;
         imm_c     = dec_ctrl.imm;
      end
   end

   assign bus.instr_ready = ready_c;
   assign bus.opCode      = opcode_c;
   assign bus.a_select    = a_sel_c;
   assign bus.b_select    = b_sel_c;
   assign bus.use_imm     = use_imm_c;
   assign bus.immediate   = imm_c;
   assign bus.regEnable   = reg_en_c;
   assign bus.flag_we     = flag_we_c;
   assign bus.done        = done_c;
   assign bus.illegal     = illegal_c;
   assign bus.retired     = retired_q;

endmodule
